// File: rtl/ram_bist.sv
// ============================================================================
// ram_bist : write/read-back self test initiator for a single-port sync RAM
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_bist #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_MULT   = 2,
  parameter int DATA_OFFSET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_writeEn,
  output logic                  ram_read,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [DATA_WIDTH-1:0] first_fail_data
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_exp_addr;
  logic                  r_cmp_valid;
  logic                  w_mismatch;
  logic [ADDR_WIDTH:0]   w_err_next;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(a) * DATA_WIDTH'(DATA_MULT) + DATA_WIDTH'(DATA_OFFSET);
  endfunction

  // ram_dout reflects the read issued one edge earlier, tracked by r_exp_addr
  assign w_mismatch = r_cmp_valid && (ram_dout != pattern(r_exp_addr));
  assign w_err_next = err_count + (ADDR_WIDTH+1)'(w_mismatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_exp_addr      <= '0;
      r_cmp_valid     <= 1'b0;
      ram_addr        <= '0;
      ram_din         <= '0;
      ram_writeEn     <= 1'b0;
      ram_read        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
    end else begin
      if (w_mismatch) begin
        err_count <= w_err_next;
        if (err_count == '0) begin
          first_fail_addr <= r_exp_addr;
          first_fail_data <= ram_dout;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state         <= S_WRITE;
            ram_addr        <= '0;
            ram_din         <= pattern('0);
            ram_writeEn     <= 1'b1;
            ram_read        <= 1'b0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
            r_cmp_valid     <= 1'b0;
          end
        end
        S_WRITE: begin
          if (ram_addr == c_LAST_ADDR) begin
            r_state     <= S_READ;
            ram_writeEn <= 1'b0;
            ram_read    <= 1'b1;
            ram_addr    <= '0;
          end else begin
            ram_addr <= ram_addr + 1'b1;
            ram_din  <= pattern(ram_addr + 1'b1);
          end
        end
        S_READ: begin
          r_exp_addr  <= ram_addr;
          r_cmp_valid <= 1'b1;
          if (ram_addr == c_LAST_ADDR) begin
            r_state  <= S_DRAIN;
            ram_read <= 1'b0;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          r_state     <= S_DONE;
          r_cmp_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          pass        <= (w_err_next == '0);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_bist.sv
// ============================================================================
// tb_ram_bist : scoreboard bench for ram_bist with a behavioural sync RAM
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_bist;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_writeEn;
  logic          ram_read;
  logic [DW-1:0] ram_dout;
  logic          busy, done, pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_fail_addr;
  logic [DW-1:0] first_fail_data;

  ram_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_MULT(2), .DATA_OFFSET(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_writeEn(ram_writeEn),
    .ram_read(ram_read), .ram_dout(ram_dout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_addr(first_fail_addr), .first_fail_data(first_fail_data)
  );

  always #5 clk = ~clk;

  // Behavioural sync RAM with per-address bit0 read corruption
  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    mem_q = '0;
  logic [AW-1:0]    rd_a = '0;
  logic [DEPTH-1:0] corrupt = '0;

  always @(posedge clk) begin
    if (ram_writeEn) mem[ram_addr] <= ram_din;
    if (ram_read) begin
      mem_q <= mem[ram_addr];
      rd_a  <= ram_addr;
    end
  end
  assign ram_dout = mem_q ^ {{(DW-1){1'b0}}, corrupt[rd_a]};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [AW:0]   err;
    logic [AW-1:0] ffa;
    logic [DW-1:0] ffd;
    logic          pas;
    int            done_cyc;
  } exp_t;
  exp_t q[$];

  // Monitor: RAM-side traffic plus result scoreboard on done rising
  int   wr_exp = 0;
  int   rd_exp = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (ram_writeEn) begin
      chk("wr_addr", 64'(ram_addr), 64'(wr_exp));
      chk("wr_din", 64'(ram_din), 64'(2 * wr_exp + 1));
      wr_exp++;
    end else wr_exp = 0;
    if (ram_read) begin
      chk("rd_addr", 64'(ram_addr), 64'(rd_exp));
      rd_exp++;
    end else rd_exp = 0;
    if (ram_writeEn && ram_read) chk("we_rd_exclusive", 64'(1), 64'(0));
    if (done && !prev_done) begin
      if (q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("err_count", 64'(err_count), 64'(e.err));
        chk("first_fail_addr", 64'(first_fail_addr), 64'(e.ffa));
        chk("first_fail_data", 64'(first_fail_data), 64'(e.ffd));
        chk("pass", 64'(pass), 64'(e.pas));
        chk("busy_at_done", 64'(busy), 64'(0));
      end
    end
    prev_done = done;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 64'(ram_addr), 0);
    chk({tag, "_din"}, 64'(ram_din), 0);
    chk({tag, "_we"}, 64'(ram_writeEn), 0);
    chk({tag, "_rd"}, 64'(ram_read), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_pass"}, 64'(pass), 0);
    chk({tag, "_err"}, 64'(err_count), 0);
    chk({tag, "_ffa"}, 64'(first_fail_addr), 0);
    chk({tag, "_ffd"}, 64'(first_fail_data), 0);
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run(input logic [DEPTH-1:0] cm, input logic [AW:0] err,
                     input logic [AW-1:0] ffa, input logic [DW-1:0] ffd,
                     input logic pas, input bit repulse);
    int   s;
    bit   seen;
    exp_t e;
    corrupt = cm;
    pulse_start(s);
    e.err = err; e.ffa = ffa; e.ffd = ffd; e.pas = pas; e.done_cyc = s + 2 * DEPTH + 1;
    q.push_back(e);
    if (repulse) begin
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (ram_writeEn && ram_addr == AW'(7)) seen = 1;
      end
      chk("repulse_point_reached", 64'(seen), 64'(1));
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_within_budget", 64'(seen), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    int  s;
    bit  seen;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run('0, 5'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    run(16'h0020, 5'd1, 4'd5, 32'd10, 1'b0, 1'b0);
    run(16'h0204, 5'd2, 4'd2, 32'd4, 1'b0, 1'b0);
    run('0, 5'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    run('0, 5'd0, 4'd0, 32'd0, 1'b1, 1'b1);

    // Abort mid-read, then a fresh run must complete cleanly
    corrupt = '0;
    pulse_start(s);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (ram_read && ram_addr == AW'(6)) seen = 1;
    end
    chk("abort_point_reached", 64'(seen), 64'(1));
    #2 rst = 1'b1;
    #1 chk_all_zero("abort");
    @(negedge clk) rst = 1'b0;
    run('0, 5'd0, 4'd0, 32'd0, 1'b1, 1'b0);

    chk("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ram_bist.md
Name: ram_bist

Overview:
Built-in self-test initiator for the single-port sync_ram. On a start pulse it drives the RAM write port to fill every address with a deterministic pattern, then reads every address back through the RAM's one-cycle registered read path. It compares each returned word against the expected value and reports pass/fail, error count and first failing location. It sits between the top-level control and sync_ram, in place of any other RAM master while active.

Parameters:
ADDR_WIDTH, 10, RAM address width; DEPTH = 2^ADDR_WIDTH
DATA_WIDTH, 32, RAM word width
DATA_MULT, 2, pattern multiplier
DATA_OFFSET, 1, pattern offset; expected(a) = (DATA_MULT*a + DATA_OFFSET) truncated to DATA_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin test; sampled only in IDLE or DONE
ram_addr  output  ADDR_WIDTH  to sync_ram addr
ram_din  output  DATA_WIDTH  to sync_ram Din
ram_writeEn  output  1  to sync_ram writeEn
ram_read  output  1  to sync_ram read
ram_dout  input  DATA_WIDTH  from sync_ram Dout; holds mem[addr] after an edge where read=1
busy  output  1  high in WRITE, READ, DRAIN
done  output  1  high in DONE until next start or reset
pass  output  1  done && err_count==0
err_count  output  ADDR_WIDTH+1  number of mismatches in the current run
first_fail_addr  output  ADDR_WIDTH  address of first mismatch
first_fail_data  output  DATA_WIDTH  data read at first mismatch

Behaviour:
- Reset (async, any state): state IDLE. All outputs 0: ram_addr, ram_din, ram_writeEn, ram_read, busy, done, pass, err_count, first_fail_addr, first_fail_data. Internal compare-valid flag cleared.
- All RAM-side outputs are registered and stable between edges.
- IDLE/DONE: start=1 at edge S -> WRITE. ram_addr=0, ram_din=expected(0), ram_writeEn=1. err_count and first_fail_* cleared. done drops.
- WRITE: each edge, RAM stores the current pair. Block advances ram_addr by 1 and sets ram_din=expected(ram_addr+1).
  - On the edge committing address DEPTH-1 (edge S+DEPTH): -> READ with ram_writeEn=0, ram_read=1, ram_addr=0.
- READ: each edge issues a read of ram_addr and records it as exp_addr, setting compare-valid. ram_addr increments.
  - After issuing DEPTH-1: -> DRAIN with ram_read=0 and ram_addr holding.
- Compare (READ and DRAIN): when compare-valid is set, ram_dout is checked against expected(exp_addr) at the edge.
  - On mismatch, err_count increments.
  - On the first mismatch of the run, first_fail_addr and first_fail_data are latched.
  - err_count never overflows, since the maximum is DEPTH.
- DRAIN: one cycle; performs the final compare (address DEPTH-1), then -> DONE.
- Latency: done=1 after edge S+2*DEPTH+1, i.e. 2*DEPTH+1 cycles after the start edge.
- ram_writeEn and ram_read are never both 1.
- start while busy: ignored, no effect.
- start in DONE: full rerun, results cleared.
- Address wrap: ram_addr never wraps during a phase; the phase ends at DEPTH-1.
- Reset mid-run: immediate abort. RAM contents are undefined; the next start performs the complete write phase.

Test Plan:
- ADDR_WIDTH=4, fault-free sync_ram, start pulse at edge S:
  - write phase drives addr 0..15 with din 1,3,...,31 (addr 3 -> 7);
  - reads issued addr 0..15;
  - done=1, pass=1, err_count=0 after edge S+33.
- ADDR_WIDTH=4, bench XORs ram_dout bit0 when the read address was 5 -> done with pass=0, err_count=1, first_fail_addr=5, first_fail_data=10.
- ADDR_WIDTH=4, corrupt reads of addresses 2 and 9 -> err_count=2, first_fail_addr=2.
- start re-pulsed during WRITE at addr 7 -> ignored; done timing unchanged, still edge S+33.
- rst asserted mid-READ (addr 6), released, then start -> all outputs 0 immediately at rst; new run completes with pass=1 after 33 cycles.
- Run with faults, then second start in DONE with clean RAM -> err_count cleared to 0, first_fail_* cleared, pass=1.
